qpu_lsu_ost: RTL

QPU_LSU_OST -- requirements
Module: QPU_lsu_ost

---
 rtl/qpu_lsu_ost_if.sv | 66 ++++++
 rtl/qpu_lsu_ost.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/qpu_lsu_ost_if.sv
// LSU request/write-back channel and DTCM command/response channel bundled
// into one interface. The slave modport is the LSU tracker's view. The master
// modport is the view of the surrounding pipeline and DTCM.
interface qpu_lsu_ost_if #(
    parameter int unsigned QPU_XLEN            = 32,
    parameter int unsigned QPU_ADDR_SIZE       = 32,
    parameter int unsigned QPU_DTCM_ADDR_WIDTH = 16
);
    // LSU request channel
    logic                           lsu_icb_cmd_valid;
    logic                           lsu_icb_cmd_ready;
    logic [QPU_ADDR_SIZE-1:0]       lsu_icb_cmd_addr;
    logic                           lsu_icb_cmd_read;
    logic [QPU_XLEN-1:0]            lsu_icb_cmd_wdata;
    logic [QPU_XLEN/8-1:0]          lsu_icb_cmd_wmask;
    logic [1:0]                     lsu_icb_cmd_size;
    logic                           lsu_icb_cmd_usign;

    // Write-back / commit channel
    logic                           lsu_o_valid;
    logic                           lsu_o_ready;
    logic [QPU_XLEN-1:0]            lsu_o_wbck_wdat;
    logic                           lsu_o_cmt_ld;
    logic                           lsu_o_cmt_st;
    logic [QPU_ADDR_SIZE-1:0]       lsu_o_cmt_badaddr;

    // DTCM command channel
    logic                           dtcm_icb_cmd_valid;
    logic                           dtcm_icb_cmd_ready;
    logic [QPU_DTCM_ADDR_WIDTH-1:0] dtcm_icb_cmd_addr;
    logic                           dtcm_icb_cmd_read;
    logic [QPU_XLEN-1:0]            dtcm_icb_cmd_wdata;
    logic [QPU_XLEN/8-1:0]          dtcm_icb_cmd_wmask;

    // DTCM response channel (in-order)
    logic                           dtcm_icb_rsp_valid;
    logic                           dtcm_icb_rsp_ready;
    logic [QPU_XLEN-1:0]            dtcm_icb_rsp_rdata;
    logic                           dtcm_icb_rsp_err;

    modport slave (
        input  lsu_icb_cmd_valid, lsu_icb_cmd_addr, lsu_icb_cmd_read, lsu_icb_cmd_wdata,
        input  lsu_icb_cmd_wmask, lsu_icb_cmd_size, lsu_icb_cmd_usign,
        output lsu_icb_cmd_ready,
        output lsu_o_valid, lsu_o_wbck_wdat, lsu_o_cmt_ld, lsu_o_cmt_st, lsu_o_cmt_badaddr,
        input  lsu_o_ready,
        output dtcm_icb_cmd_valid, dtcm_icb_cmd_addr, dtcm_icb_cmd_read, dtcm_icb_cmd_wdata,
        output dtcm_icb_cmd_wmask,
        input  dtcm_icb_cmd_ready,
        input  dtcm_icb_rsp_valid, dtcm_icb_rsp_rdata, dtcm_icb_rsp_err,
        output dtcm_icb_rsp_ready
    );

    modport master (
        output lsu_icb_cmd_valid, lsu_icb_cmd_addr, lsu_icb_cmd_read, lsu_icb_cmd_wdata,
        output lsu_icb_cmd_wmask, lsu_icb_cmd_size, lsu_icb_cmd_usign,
        input  lsu_icb_cmd_ready,
        input  lsu_o_valid, lsu_o_wbck_wdat, lsu_o_cmt_ld, lsu_o_cmt_st, lsu_o_cmt_badaddr,
        output lsu_o_ready,
        input  dtcm_icb_cmd_valid, dtcm_icb_cmd_addr, dtcm_icb_cmd_read, dtcm_icb_cmd_wdata,
        input  dtcm_icb_cmd_wmask,
        output dtcm_icb_cmd_ready,
        output dtcm_icb_rsp_valid, dtcm_icb_rsp_rdata, dtcm_icb_rsp_err,
        input  dtcm_icb_rsp_ready
    );
endinterface

// File: rtl/qpu_lsu_ost.sv
// LSU outstanding-request tracker in front of the DTCM.
// Each accepted request is logged in an in-order FIFO. Requests with local
// errors (misaligned or out of DTCM range) are logged but never sent to DTCM.
// They retire in order with the DTCM responses and report commit exceptions.
module qpu_lsu_ost #(
    parameter int unsigned QPU_XLEN            = 32,
    parameter int unsigned QPU_ADDR_SIZE       = 32,
    parameter int unsigned QPU_DTCM_ADDR_WIDTH = 16,
    parameter int unsigned OST_DEPTH           = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    qpu_lsu_ost_if.slave       bus,
    output logic               lsu_active
);

    localparam int unsigned PtrW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(OST_DEPTH + 1);
    localparam int unsigned OffW = $clog2(QPU_XLEN / 8);

    typedef struct packed {
        logic                     read;
        logic [1:0]               size;
        logic                     usign;
        logic [QPU_ADDR_SIZE-1:0] addr;
        logic                     lerr;
    } ost_entry_t;

    ost_entry_t          fifo_q [OST_DEPTH];
    ost_entry_t          fifo_d [OST_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic                full;
    logic                empty;
    logic                misalign;
    logic                out_of_range;
    logic                req_lerr;
    logic                push;
    logic                pop;
    ost_entry_t          head;
    logic                head_err;
    logic [QPU_XLEN-1:0] rdata_sh;
    logic                ld_sign;
    int unsigned         ld_bits;
    logic [QPU_XLEN-1:0] ld_ext;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(OST_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full  = (cnt_q == CntW'(OST_DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    // Classify the incoming request: alignment by size, range by upper address bits
    always_comb begin
        misalign = 1'b0;
        case (bus.lsu_icb_cmd_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = bus.lsu_icb_cmd_addr[0];
            2'd2:    misalign = |bus.lsu_icb_cmd_addr[1:0];
            default: misalign = |bus.lsu_icb_cmd_addr[2:0];
        endcase
        out_of_range = |(bus.lsu_icb_cmd_addr >> QPU_DTCM_ADDR_WIDTH);
        req_lerr     = misalign | out_of_range;
    end

    // Request side: errored requests bypass DTCM and only need a free FIFO slot
    always_comb begin
        bus.lsu_icb_cmd_ready  = !full && (req_lerr || bus.dtcm_icb_cmd_ready);
        bus.dtcm_icb_cmd_valid = bus.lsu_icb_cmd_valid && !full && !req_lerr;
        bus.dtcm_icb_cmd_addr  = bus.lsu_icb_cmd_addr[QPU_DTCM_ADDR_WIDTH-1:0];
        bus.dtcm_icb_cmd_read  = bus.lsu_icb_cmd_read;
        bus.dtcm_icb_cmd_wdata = bus.lsu_icb_cmd_wdata;
        bus.dtcm_icb_cmd_wmask = bus.lsu_icb_cmd_wmask;
        push                   = bus.lsu_icb_cmd_valid && bus.lsu_icb_cmd_ready;
        lsu_active             = bus.lsu_icb_cmd_valid || !empty;
    end

    // Align the response to the head's byte lane, then sign/zero extend
    always_comb begin
        rdata_sh = bus.dtcm_icb_rsp_rdata >> {head.addr[OffW-1:0], 3'b000};
        case (head.size)
            2'd0:    begin ld_bits = 8;  ld_sign = rdata_sh[7];  end
            2'd1:    begin ld_bits = 16; ld_sign = rdata_sh[15]; end
            2'd2:    begin ld_bits = 32; ld_sign = rdata_sh[31]; end
            default: begin ld_bits = 64; ld_sign = rdata_sh[QPU_XLEN-1]; end
        endcase
        for (int unsigned i = 0; i < QPU_XLEN; i++) begin
            ld_ext[i] = (i < ld_bits) ? rdata_sh[i] : (ld_sign & ~head.usign);
        end
    end

    // Write-back side: head retires when its error is known or DTCM answers
    always_comb begin
        head_err              = head.lerr || (bus.dtcm_icb_rsp_valid && bus.dtcm_icb_rsp_err);
        bus.lsu_o_valid       = !empty && (head.lerr || bus.dtcm_icb_rsp_valid);
        // Errored heads never consume a DTCM response
        bus.dtcm_icb_rsp_ready = !empty && !head.lerr && bus.lsu_o_ready;
        bus.lsu_o_cmt_ld      = bus.lsu_o_valid && head_err && head.read;
        bus.lsu_o_cmt_st      = bus.lsu_o_valid && head_err && !head.read;
        bus.lsu_o_cmt_badaddr = (bus.lsu_o_valid && head_err) ? head.addr : '0;
        bus.lsu_o_wbck_wdat   = (bus.lsu_o_valid && head.read && !head_err) ? ld_ext : '0;
        pop                   = bus.lsu_o_valid && bus.lsu_o_ready;
    end

    // Next-state for FIFO storage, pointers and occupancy
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            fifo_d[wr_ptr_q] = '{read:  bus.lsu_icb_cmd_read,
                                 size:  bus.lsu_icb_cmd_size,
                                 usign: bus.lsu_icb_cmd_usign,
                                 addr:  bus.lsu_icb_cmd_addr,
                                 lerr:  req_lerr};
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State registers; reset discards all in-flight entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(OST_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
